// File: rtl/clock_pkg.sv
// Shared constants and types for the front-panel clock design.
// Holds button indices, the channel FSM state type and a counter width helper.
package clock_pkg;

    localparam int CLK_HZ  = 100_000_000;

    localparam int NUM_BTN = 3;
    localparam int BTN_L   = 0;
    localparam int BTN_M   = 1;
    localparam int BTN_R   = 2;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } btn_state_e;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One push-button conditioner: synchroniser, debouncer and press/hold FSM.
// Ports: clk, rst (sync, active-high), raw pin in; level, press, short_rel,
// long_hold and auto_rep out (level is a debounced level, the rest are
// one-cycle registered pulses).
module btn_channel
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 2_500_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic short_rel,
    output logic long_hold,
    output logic auto_rep
);

    // A chain shorter than two flops is not a synchroniser.
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam int LW = cnt_w(LONG_CYCLES);
    localparam int RW = cnt_w(REPEAT_CYCLES);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    // Pin capture flop, then the metastability chain.
    logic          pin_q;
    logic [SS-1:0] sync_q;
    logic          sync;

    logic [DW-1:0] db_cnt;
    logic [DW-1:0] db_cnt_d;
    logic          level_d;
    logic          rise;
    logic          fall;

    btn_state_e    state_q;
    btn_state_e    state_d;
    logic [LW-1:0] hold_q;
    logic [LW-1:0] hold_d;
    logic [RW-1:0] rep_q;
    logic [RW-1:0] rep_d;

    logic          press_d;
    logic          short_d;
    logic          long_d;
    logic          rep_p_d;

    assign sync = sync_q[SS-1];

    // Debounce: a level change is accepted only after the synchronised
    // value has differed from the current level for DEBOUNCE_CYCLES
    // consecutive cycles; any agreeing cycle restarts the count.
    always_comb begin
        level_d  = level;
        db_cnt_d = '0;
        if (sync != level) begin
            if (db_cnt == DB_LAST) begin
                level_d = sync;
            end else begin
                db_cnt_d = db_cnt + 1'b1;
            end
        end
    end

    // The FSM looks at the next level so that press/short land on the
    // same edge that updates btn_level.
    assign rise = level_d & ~level;
    assign fall = ~level_d & level;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rep_d   = rep_q;
        press_d = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_p_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    hold_d  = '0;
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                // A release on the cycle the long pulse would be due
                // still counts as a short press: long has not fired.
                if (fall) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end else if (hold_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    rep_d   = '0;
                    state_d = HELD;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            HELD: begin
                // Release wins over a repeat that is due this cycle.
                if (fall) begin
                    state_d = IDLE;
                end else if (rep_q == REP_LAST) begin
                    rep_p_d = 1'b1;
                    rep_d   = '0;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pin_q     <= 1'b0;
            sync_q    <= '0;
            db_cnt    <= '0;
            level     <= 1'b0;
            state_q   <= IDLE;
            hold_q    <= '0;
            rep_q     <= '0;
            press     <= 1'b0;
            short_rel <= 1'b0;
            long_hold <= 1'b0;
            auto_rep  <= 1'b0;
        end else begin
            pin_q     <= raw;
            sync_q    <= {sync_q[SS-2:0], pin_q};
            db_cnt    <= db_cnt_d;
            level     <= level_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            press     <= press_d;
            short_rel <= short_d;
            long_hold <= long_d;
            auto_rep  <= rep_p_d;
        end
    end

endmodule

// File: rtl/button_cond.sv
// Front-panel input conditioner for the left/middle/right push buttons.
// Ports: clk, rst (sync, active-high), btn_raw[2:0]; per-button btn_level,
// btn_press, btn_short, btn_long, btn_repeat (bit0=L, bit1=M, bit2=R).
module button_cond
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 2_500_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BTN-1:0]   btn_raw,
    output logic [NUM_BTN-1:0]   btn_level,
    output logic [NUM_BTN-1:0]   btn_press,
    output logic [NUM_BTN-1:0]   btn_short,
    output logic [NUM_BTN-1:0]   btn_long,
    output logic [NUM_BTN-1:0]   btn_repeat
);

    // Channels share nothing but clock and reset.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .raw       (btn_raw[i]),
            .level     (btn_level[i]),
            .press     (btn_press[i]),
            .short_rel (btn_short[i]),
            .long_hold (btn_long[i]),
            .auto_rep  (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_cond.sv
// Self-checking bench for button_cond with small timing parameters.
// Directed scenarios plus randomized bouncing stimulus against a model.
module tb_button_cond;

    localparam int S = 2;
    localparam int D = 4;
    localparam int L = 16;
    localparam int R = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [2:0] btn_short;
    logic [2:0] btn_long;
    logic [2:0] btn_repeat;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    button_cond #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_short  (btn_short),
        .btn_long   (btn_long),
        .btn_repeat (btn_repeat)
    );

    // Reference model: raw samples are delayed by the pin flop plus the
    // synchroniser; a level flips after D consecutive differing samples;
    // events derive from the time elapsed since the press.
    logic [2:0] dly [0:S];
    int         run [3];
    int         pe  [3];
    int         edge_n = 0;
    logic [2:0] m_level = '0;
    logic [2:0] m_press = '0;
    logic [2:0] m_short = '0;
    logic [2:0] m_long  = '0;
    logic [2:0] m_rep   = '0;

    task automatic model_edge(input logic r, input logic [2:0] raw);
        logic old;
        logic nl;
        logic d;
        int   e;
        m_press = '0;
        m_short = '0;
        m_long  = '0;
        m_rep   = '0;
        if (r) begin
            for (int k = 0; k <= S; k++) dly[k] = '0;
            for (int c = 0; c < 3; c++) run[c] = 0;
            m_level = '0;
        end else begin
            edge_n++;
            for (int c = 0; c < 3; c++) begin
                old = m_level[c];
                d   = dly[S][c];
                nl  = old;
                if (d != old) begin
                    run[c]++;
                    if (run[c] == D) begin
                        nl     = d;
                        run[c] = 0;
                    end
                end else begin
                    run[c] = 0;
                end
                m_level[c] = nl;
                if (nl && !old) begin
                    m_press[c] = 1'b1;
                    pe[c]      = edge_n;
                end else if (!nl && old) begin
                    if (edge_n - pe[c] <= L) m_short[c] = 1'b1;
                end else if (nl) begin
                    e = edge_n - pe[c];
                    if (e == L) m_long[c] = 1'b1;
                    else if (e > L && (e - L) % R == 0) m_rep[c] = 1'b1;
                end
            end
            for (int k = S; k > 0; k--) dly[k] = dly[k-1];
            dly[0] = raw;
        end
    endtask

    function automatic logic [14:0] exp_vec();
        return {m_rep, m_long, m_short, m_press, m_level};
    endfunction

    function automatic logic [14:0] obs_vec();
        return {btn_repeat, btn_long, btn_short, btn_press, btn_level};
    endfunction

    task automatic step(input logic r, input logic [2:0] raw);
        @(negedge clk);
        rst     = r;
        btn_raw = raw;
        @(posedge clk);
        model_edge(r, raw);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 3'b000);
        step(1'b1, 3'b111);
        checks++;
        if (obs_vec() !== 15'h0) begin
            errors++;
            $display("FAIL reset_state got=%h want=0", obs_vec());
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 3'b000);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle i=%0d got=%h want=%h",
                         i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clean_press();
        int at = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, (i < 12) ? 3'b001 : 3'b000);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL clean i=%0d got=%h want=%h",
                         i, obs_vec(), exp_vec());
            end
            if (btn_press[0] && at < 0) at = i;
        end
        checks++;
        if (at !== S + D) begin
            errors++;
            $display("FAIL clean_latency got=%0d want=%0d", at, S + D);
        end
    endtask

    task automatic test_glitch();
        int lv3 = 0;
        int pr4 = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, (i < 3) ? 3'b100 : 3'b000);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL glitch3 i=%0d got=%h want=%h",
                         i, obs_vec(), exp_vec());
            end
            if (btn_level[2]) lv3++;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, (i < 4) ? 3'b100 : 3'b000);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL glitch4 i=%0d got=%h want=%h",
                         i, obs_vec(), exp_vec());
            end
            if (btn_press[2]) pr4++;
        end
        checks++;
        if (lv3 !== 0) begin
            errors++;
            $display("FAIL glitch3_level got=%0d want=0", lv3);
        end
        checks++;
        if (pr4 !== 1) begin
            errors++;
            $display("FAIL glitch4_press got=%0d want=1", pr4);
        end
    endtask

    task automatic test_short();
        int np = 0;
        int ns = 0;
        int nl = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, (i < 10) ? 3'b010 : 3'b000);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL short i=%0d got=%h want=%h",
                         i, obs_vec(), exp_vec());
            end
            np += int'(btn_press[1]);
            ns += int'(btn_short[1]);
            nl += int'(btn_long[1]);
        end
        checks++;
        if (np !== 1 || ns !== 1 || nl !== 0) begin
            errors++;
            $display("FAIL short_counts got=%0d/%0d/%0d want=1/1/0",
                     np, ns, nl);
        end
    endtask

    task automatic test_long_repeat();
        int p  = -1;
        int lg = -1;
        int ns = 0;
        int rp[$];
        for (int i = 0; i < 85; i++) begin
            step(1'b0, (i < 60) ? 3'b010 : 3'b000);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL long i=%0d got=%h want=%h",
                         i, obs_vec(), exp_vec());
            end
            if (btn_press[1]) p = i;
            if (btn_long[1]) lg = i;
            if (btn_repeat[1]) rp.push_back(i);
            ns += int'(btn_short[1]);
        end
        checks++;
        if (p < 0 || lg - p !== L) begin
            errors++;
            $display("FAIL long_offset got=%0d want=%0d", lg - p, L);
        end
        checks++;
        if (rp.size() < 3) begin
            errors++;
            $display("FAIL repeat_count got=%0d want>=3", rp.size());
        end else if (rp[0] - lg !== 8 || rp[1] - lg !== 16 ||
                     rp[2] - lg !== 24) begin
            errors++;
            $display("FAIL repeat_offsets got=%0d,%0d,%0d want=8,16,24",
                     rp[0] - lg, rp[1] - lg, rp[2] - lg);
        end
        checks++;
        if (ns !== 0) begin
            errors++;
            $display("FAIL long_no_short got=%0d want=0", ns);
        end
    endtask

    task automatic test_simultaneous();
        int a = -1;
        int b = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, (i < 10) ? 3'b101 : 3'b000);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL simul i=%0d got=%h want=%h",
                         i, obs_vec(), exp_vec());
            end
            if (btn_press[0]) a = i;
            if (btn_press[2]) b = i;
        end
        checks++;
        if (a < 0 || a !== b) begin
            errors++;
            $display("FAIL simul_press got=%0d,%0d want=equal", a, b);
        end
    endtask

    task automatic test_reset_mid_hold();
        int p = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 3'b010);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rsthold_pre i=%0d got=%h want=%h",
                         i, obs_vec(), exp_vec());
            end
        end
        step(1'b1, 3'b010);
        checks++;
        if (obs_vec() !== 15'h0) begin
            errors++;
            $display("FAIL rsthold_clear got=%h want=0", obs_vec());
        end
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 3'b010);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rsthold_post i=%0d got=%h want=%h",
                         i, obs_vec(), exp_vec());
            end
            if (btn_press[1] && p < 0) p = i;
        end
        checks++;
        if (p !== S + D + 1) begin
            errors++;
            $display("FAIL rsthold_refire got=%0d want=%0d", p, S + D + 1);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 3'b000);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rsthold_tail i=%0d got=%h want=%h",
                         i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] raw = '0;
        int         left [3];
        logic       r;
        int         np;
        for (int c = 0; c < 3; c++) left[c] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 3; c++) begin
                if (left[c] == 0) begin
                    raw[c]  = 1'($urandom_range(0, 1));
                    left[c] = ($urandom_range(0, 3) == 0)
                            ? int'($urandom_range(1, 5))
                            : int'($urandom_range(1, 60));
                end
                left[c]--;
            end
            r = ($urandom_range(0, 599) == 0);
            step(r, raw);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random i=%0d got=%h want=%h",
                         i, obs_vec(), exp_vec());
            end
            for (int c = 0; c < 3; c++) begin
                np = int'(btn_press[c]) + int'(btn_short[c]) +
                     int'(btn_long[c]) + int'(btn_repeat[c]);
                if (np > 1) begin
                    checks++;
                    errors++;
                    $display("FAIL exclusive ch=%0d i=%0d got=%0d want<=1",
                             c, i, np);
                end
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = '0;
        for (int k = 0; k <= S; k++) dly[k] = '0;
        for (int c = 0; c < 3; c++) begin
            run[c] = 0;
            pe[c]  = 0;
        end
        test_reset();
        test_clean_press();
        test_glitch();
        test_short();
        test_long_repeat();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
